regfile_dbg_master: RTL and testbench
=====================================

REGFILE_DBG_MASTER -- requirements
Module: regfile_dbg_master

Interface
REQ-001 Parameter W, default 32, data width of one register.
REQ-002 Parameter AW, default 5, register address width; register count N = 2**AW.
REQ-003 clk  in  1  clock, all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-007 cmd_op  in  1  0 = dump (read registers out), 1 = load (write registers in).
REQ-008 cmd_base  in  AW  first register address.
REQ-009 cmd_count  in  AW+1  number of registers to transfer.
REQ-010 out_valid / out_ready  out / in  1  dump stream handshake.
REQ-011 out_data / out_addr  out  W / AW  dumped register value and its address.
REQ-012 in_valid / in_ready  in / out  1  load stream handshake.
REQ-013 in_data  in  W  value to load.
REQ-014 rf_a1  out  AW  register-file read address; rf_rd1  in  W  combinational read data.
REQ-015 rf_a3 / rf_we3 / rf_wd3  out  AW / 1 / W  register-file write port.
REQ-016 busy  out  1  high in any state other than IDLE; done  out  1  one-cycle completion pulse.

Function
REQ-017 The FSM SHALL have states IDLE, DUMP, LOAD and DONE.
REQ-018 cmd_ready SHALL be high only in IDLE; the command is accepted on cmd_valid && cmd_ready.
REQ-019 On acceptance, addr SHALL load cmd_base and remaining SHALL load min(cmd_count, N).
- A count of 0 SHALL go directly to DONE with no transfers.
- A nonzero count SHALL go to DUMP if cmd_op = 0, or to LOAD if cmd_op = 1.
REQ-020 Addresses SHALL increment modulo N after each transfer; 31 wraps to 0 for AW = 5.
REQ-021 In DUMP, rf_a1 SHALL equal addr, and the output stage SHALL be registered.
- When the stage is empty or out_ready is high, out_data <= rf_rd1 and out_addr <= addr.
- In the same cycle out_valid <= 1, addr increments and remaining decrements.
REQ-022 The first dump beat SHALL appear with out_valid the cycle after acceptance.
- With out_ready held high, throughput SHALL be one register per cycle.
REQ-023 When out_valid && !out_ready, out_data, out_addr and out_valid SHALL hold stable.
REQ-024 DUMP SHALL move to DONE on the handshake of the last beat, which clears out_valid.
REQ-025 In LOAD, in_ready SHALL be high.
- rf_we3 SHALL equal in_valid && in_ready, combinationally.
- rf_a3 SHALL equal addr and rf_wd3 SHALL equal in_data in the same cycle.
REQ-026 On each LOAD handshake, addr SHALL increment and remaining SHALL decrement.
- LOAD SHALL move to DONE after the handshake where remaining = 1.
REQ-027 rf_we3 SHALL be 0 in every state except LOAD; in_ready SHALL be 0 outside LOAD; out_valid SHALL be 0 outside DUMP.
REQ-028 DONE SHALL last exactly one cycle, assert done, and return to IDLE.
- A new command SHALL NOT be accepted before the next cycle.
REQ-029 Address 0 SHALL be written like any other address; protecting register 0 is not this block's job.

Reset
REQ-030 While rst is low, all of the following SHALL be 0 and the state SHALL be IDLE: out_valid, out_data, out_addr, addr, remaining, done, busy, rf_we3, in_ready.
REQ-031 Reset asserted mid-transfer SHALL abort immediately, with no further rf_we3 pulse and no completion done.

Structure
REQ-032 The FSM state encoding and the op encodings (DUMP_OP = 0, LOAD_OP = 1) SHALL live in the shared processor package.
REQ-033 The block SHALL be a single module with no sub-modules; the address/remaining counter is inline.

Verification
REQ-034 Dump, base 0, count 4, out_ready = 1, registers preloaded with 0x10..0x13.
- Beats (0,0x10) (1,0x11) (2,0x12) (3,0x13) on consecutive cycles.
- done one cycle after the last beat.
REQ-035 Dump, base 30, count 4.
- out_addr sequence 30, 31, 0, 1 (wrap-around).
REQ-036 Dump with out_ready low for 3 cycles on beat 2.
- out_data and out_addr stable while stalled; no beat lost or duplicated.
REQ-037 Load, base 5, count 3, in_data 0xA, 0xB, 0xC with one idle in_valid gap.
- Exactly three rf_we3 pulses at addresses 5, 6, 7; a subsequent dump reads 0xA, 0xB, 0xC.
REQ-038 Count 0 -> done the cycle after acceptance, with no rf_we3 and no out_valid.
- Count 40 -> exactly 32 transfers.
REQ-039 rst low after 2 of 6 load beats.
- Outputs zero, no further writes, no done; the next command is accepted normally after reset releases.

Source files
------------

// File: rtl/regfile_dbg_master_pkg.sv
// Shared processor package: FSM state and command-op encodings used by the
// register-file debug master.
package regfile_dbg_master_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_DUMP = 2'd1;
  localparam state_t ST_LOAD = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  localparam logic DUMP_OP = 1'b0;
  localparam logic LOAD_OP = 1'b1;

endpackage

// File: rtl/regfile_dbg_master.sv
// Register-file debug master: streams a block of registers out (dump) or
// writes a block of registers from an input stream (load). A single address
// pointer and a remaining-transfer count drive both directions; the dump path
// has one registered output stage so rf_rd1 never feeds out_data directly.
module regfile_dbg_master #(
  parameter int W  = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_op,
  input  logic [AW-1:0] cmd_base,
  input  logic [AW:0]   cmd_count,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [AW-1:0] out_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic [AW-1:0] rf_a1,
  input  logic [W-1:0]  rf_rd1,
  output logic [AW-1:0] rf_a3,
  output logic          rf_we3,
  output logic [W-1:0]  rf_wd3,
  output logic          busy,
  output logic          done
);

  import regfile_dbg_master_pkg::*;

  localparam int          N     = 1 << AW;
  localparam logic [AW:0] N_CNT = (AW+1)'(N);

  state_t        state;
  logic [AW-1:0] addr;
  logic [AW:0]   remaining;

  logic          accept;
  logic          out_fire;
  logic          in_fire;
  logic          stage_load;
  logic          load_step;
  logic [AW:0]   clamped_count;

  assign accept        = cmd_valid && cmd_ready;
  assign out_fire      = out_valid && out_ready;
  assign in_fire       = in_valid && in_ready;
  assign clamped_count = (cmd_count > N_CNT) ? N_CNT : cmd_count;

  // The output stage refills whenever it is empty or its current beat is
  // being taken, as long as registers are left to read.
  assign stage_load = (state == ST_DUMP) && (remaining != '0) && (!out_valid || out_ready);
  assign load_step  = (state == ST_LOAD) && in_fire;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign in_ready  = (state == ST_LOAD);
  assign rf_a1     = addr;
  assign rf_a3     = addr;
  assign rf_wd3    = in_data;
  assign rf_we3    = in_fire;

  // Command sequencing: a zero count completes at once, otherwise the op
  // picks the direction; each transfer state exits on its final handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (clamped_count == '0)
              state <= ST_DONE;
            else if (cmd_op == LOAD_OP)
              state <= ST_LOAD;
            else
              state <= ST_DUMP;
          end
        end
        ST_DUMP: begin
          if (out_fire && (remaining == '0))
            state <= ST_DONE;
        end
        ST_LOAD: begin
          if (in_fire && (remaining == (AW+1)'(1)))
            state <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Address pointer wraps naturally at N; remaining counts transfers still owed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr      <= '0;
      remaining <= '0;
    end else if (accept) begin
      addr      <= cmd_base;
      remaining <= clamped_count;
    end else if (stage_load || load_step) begin
      addr      <= addr + AW'(1);
      remaining <= remaining - (AW+1)'(1);
    end
  end

  // Registered dump stage: capture the read data with its address, hold it
  // while the consumer stalls, and drop valid once the last beat is taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
    end else if (stage_load) begin
      out_valid <= 1'b1;
      out_data  <= rf_rd1;
      out_addr  <= addr;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_dbg_master.sv
// Self-checking bench for regfile_dbg_master: directed corner cases plus
// randomized commands, checked against a register-array model.
module tb_regfile_dbg_master;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int N  = 32;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [AW-1:0] cmd_base;
  logic [AW:0]   cmd_count;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [AW-1:0] out_addr;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [AW-1:0] rf_a1;
  logic [W-1:0]  rf_rd1;
  logic [AW-1:0] rf_a3;
  logic          rf_we3;
  logic [W-1:0]  rf_wd3;
  logic          busy;
  logic          done;

  logic          preload;
  logic [W-1:0]  bench_rf [N];
  logic [W-1:0]  model_rf [N];

  int checks = 0;
  int errors = 0;

  regfile_dbg_master #(.W(W), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_base  (cmd_base),
    .cmd_count (cmd_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rf_a1     (rf_a1),
    .rf_rd1    (rf_rd1),
    .rf_a3     (rf_a3),
    .rf_we3    (rf_we3),
    .rf_wd3    (rf_wd3),
    .busy      (busy),
    .done      (done)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file attached to the master: combinational read, clocked write.
  assign rf_rd1 = bench_rf[rf_a1];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < N; i++) bench_rf[i] <= 32'h10 + i;
    end else if (rf_we3) begin
      bench_rf[rf_a3] <= rf_wd3;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    checkOutput({tag, "_out_data"},  64'(out_data),  64'(0));
    checkOutput({tag, "_out_addr"},  64'(out_addr),  64'(0));
    checkOutput({tag, "_done"},      64'(done),      64'(0));
    checkOutput({tag, "_busy"},      64'(busy),      64'(0));
    checkOutput({tag, "_rf_we3"},    64'(rf_we3),    64'(0));
    checkOutput({tag, "_in_ready"},  64'(in_ready),  64'(0));
    checkOutput({tag, "_addr"},      64'(rf_a1),     64'(0));
  endtask

  // One command from acceptance to completion (or to an abort by reset).
  // Inputs are driven just after the falling edge; outputs are sampled 1ns later.
  task automatic applyStimulus(input logic op, input int base, input int count,
                               input int stall_pct, input int stall_beat,
                               input int gap_pct, input int gap_beat,
                               input int abort_after);
    int          exp_n;
    int          beat_addr[$];
    logic [W-1:0] beat_data[$];
    int          beat_cyc[$];
    int          wr_addr[$];
    logic [W-1:0] wr_data[$];
    logic [W-1:0] sent[$];
    int          loaded;
    int          stall_cnt;
    bit          gap_done;
    int          last_xfer;
    int          done_at;
    bit          finished;
    bit          aborted;
    bit          model_load;
    bit          exp_we;
    bit          prev_hold;
    logic [W-1:0] prev_data;
    logic [AW-1:0] prev_addr;
    int          a;

    exp_n     = (count > N) ? N : count;
    loaded    = 0;
    stall_cnt = 0;
    gap_done  = 1'b0;
    last_xfer = 0;
    done_at   = -1;
    finished  = 1'b0;
    aborted   = 1'b0;
    prev_hold = 1'b0;
    prev_data = '0;
    prev_addr = '0;

    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_base  = AW'(base);
    cmd_count = (AW+1)'(count);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    checkOutput("cmd_ready_idle", 64'(cmd_ready), 64'(1));

    for (int k = 1; k <= 600 && !finished && !aborted; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;

      if (abort_after > 0 && loaded == abort_after) begin
        rst      = 1'b0;
        in_valid = 1'b1;
        #1;
        checkResetOutputs("abort");
        repeat (3) begin
          @(negedge clk);
          #1;
          checkOutput("abort_no_write", 64'(rf_we3), 64'(0));
          checkOutput("abort_no_done",  64'(done),   64'(0));
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        aborted  = 1'b1;
      end else begin
        if (stall_beat >= 0 && out_valid && beat_addr.size() == stall_beat && stall_cnt < 3) begin
          out_ready = 1'b0;
          stall_cnt++;
        end else begin
          out_ready = ($urandom_range(0, 99) >= stall_pct);
        end
        in_data = $urandom;
        if (gap_beat >= 0 && loaded == gap_beat && !gap_done) begin
          in_valid = 1'b0;
          gap_done = 1'b1;
        end else begin
          in_valid = ($urandom_range(0, 99) >= gap_pct);
        end
        #1;

        model_load = (op == 1'b1) && (loaded < exp_n);
        exp_we     = in_valid && model_load;
        checkOutput("rf_we3", 64'(rf_we3), 64'(exp_we));
        checkOutput("in_ready", 64'(in_ready), 64'(model_load));
        if (exp_we) begin
          sent.push_back(in_data);
          loaded++;
          last_xfer = k;
        end
        if (rf_we3) begin
          wr_addr.push_back(int'(rf_a3));
          wr_data.push_back(rf_wd3);
        end
        if (op == 1'b1 || exp_n == 0)
          checkOutput("out_valid_not_dump", 64'(out_valid), 64'(0));

        if (prev_hold) begin
          checkOutput("hold_valid", 64'(out_valid), 64'(1));
          checkOutput("hold_data",  64'(out_data),  64'(prev_data));
          checkOutput("hold_addr",  64'(out_addr),  64'(prev_addr));
        end
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
        prev_addr = out_addr;

        if (out_valid && out_ready) begin
          beat_addr.push_back(int'(out_addr));
          beat_data.push_back(out_data);
          beat_cyc.push_back(k);
          last_xfer = k;
        end

        if (done) begin
          done_at  = k;
          finished = 1'b1;
          checkOutput("done_busy",      64'(busy),      64'(1));
          checkOutput("done_cmd_ready", 64'(cmd_ready), 64'(0));
          checkOutput("done_out_valid", 64'(out_valid), 64'(0));
        end
      end
    end

    if (aborted) begin
      checkOutput("abort_write_count", 64'(wr_addr.size()), 64'(abort_after));
      for (int i = 0; i < abort_after; i++) begin
        a = (base + i) % N;
        model_rf[a] = sent[i];
      end
    end else begin
      checkOutput("done_timeout", 64'(finished), 64'(1));
      checkOutput("done_cycle", 64'(done_at), 64'(last_xfer + 1));
      if (op == 1'b0) begin
        checkOutput("beat_count", 64'(beat_addr.size()), 64'(exp_n));
        for (int i = 0; i < beat_addr.size() && i < exp_n; i++) begin
          a = (base + i) % N;
          checkOutput("beat_addr", 64'(beat_addr[i]), 64'(a));
          checkOutput("beat_data", 64'(beat_data[i]), 64'(model_rf[a]));
          if (stall_pct == 0 && stall_beat < 0 && i > 0)
            checkOutput("beat_back_to_back", 64'(beat_cyc[i]), 64'(beat_cyc[i-1] + 1));
        end
      end else begin
        checkOutput("write_count", 64'(wr_addr.size()), 64'(exp_n));
        for (int i = 0; i < wr_addr.size() && i < exp_n && i < sent.size(); i++) begin
          a = (base + i) % N;
          checkOutput("write_addr", 64'(wr_addr[i]), 64'(a));
          checkOutput("write_data", 64'(wr_data[i]), 64'(sent[i]));
        end
        for (int i = 0; i < sent.size(); i++) begin
          a = (base + i) % N;
          model_rf[a] = sent[i];
        end
      end
      @(negedge clk);
      #1;
      checkOutput("after_done_low",  64'(done),      64'(0));
      checkOutput("after_busy_low",  64'(busy),      64'(0));
      checkOutput("after_cmd_ready", 64'(cmd_ready), 64'(1));
    end
  endtask

  // Directed corner cases first, then a batch of random commands.
  initial begin
    rst       = 1'b0;
    preload   = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_base  = '0;
    cmd_count = '0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    for (int i = 0; i < N; i++) model_rf[i] = 32'h10 + i;

    repeat (2) @(negedge clk);
    preload   = 1'b0;
    cmd_valid = 1'b1;
    in_valid  = 1'b1;
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    cmd_valid = 1'b0;
    in_valid  = 1'b0;
    rst       = 1'b1;

    $display("[TB] dump base 0 count 4");
    applyStimulus(1'b0, 0, 4, 0, -1, 0, -1, 0);
    $display("[TB] dump base 30 count 4 (wrap)");
    applyStimulus(1'b0, 30, 4, 0, -1, 0, -1, 0);
    $display("[TB] dump with 3-cycle stall on beat 2");
    applyStimulus(1'b0, 0, 6, 0, 2, 0, -1, 0);
    $display("[TB] load base 5 count 3 with one gap");
    applyStimulus(1'b1, 5, 3, 0, -1, 0, 1, 0);
    applyStimulus(1'b0, 5, 3, 0, -1, 0, -1, 0);
    $display("[TB] zero-count commands");
    applyStimulus(1'b0, 9, 0, 0, -1, 0, -1, 0);
    applyStimulus(1'b1, 9, 0, 0, -1, 0, -1, 0);
    $display("[TB] count 40 clamps to 32");
    applyStimulus(1'b0, 0, 40, 0, -1, 0, -1, 0);
    applyStimulus(1'b1, 7, 40, 0, -1, 20, -1, 0);
    applyStimulus(1'b0, 3, 40, 30, -1, 0, -1, 0);
    $display("[TB] reset after 2 of 6 load beats");
    applyStimulus(1'b1, 10, 6, 0, -1, 0, -1, 2);
    applyStimulus(1'b0, 10, 6, 0, -1, 0, -1, 0);

    $display("[TB] random commands");
    for (int t = 0; t < 16; t++) begin
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
                    int'($urandom_range(0, 40)), 30, -1, 30, -1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
